// File: rtl/fa_bist_checker.sv
// Built-in self-test engine that sweeps every input vector of an N-bit adder and checks it against a+b+cin.
// Optional macro FA_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module fa_bist_checker #(
    parameter int N             = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N-1:0]     dut_a,
    output logic [N-1:0]     dut_b,
    output logic             dut_cin,
    input  logic [N-1:0]     dut_s,
    input  logic             dut_cout,
    output logic [2*N+1:0]   err_count,
    output logic [2*N:0]     first_fail
);

    localparam int VW = 2 * N + 1;
    localparam int CW = 2 * N + 2;
    localparam logic [VW-1:0] V_LAST      = '1;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [VW-1:0]   vec, vec_next;
    logic [7:0]      settle_cnt, settle_cnt_next;
    logic [CW-1:0]   err_next;
    logic [VW-1:0]   first_fail_next;
    logic            pass_next;
    logic [N:0]      golden;
    logic            match;
    logic            miscompare;
    logic            stop_now;

    // The vector register is the stimulus itself, so the adder sees a clean registered input.
    assign dut_a   = vec[N-1:0];
    assign dut_b   = vec[2*N-1:N];
    assign dut_cin = vec[2*N];
    assign busy    = (state == SETTLE) || (state == CHECK);
    assign done    = (state == DONE);

    assign golden = {1'b0, vec[N-1:0]} + {1'b0, vec[2*N-1:N]} + {{N{1'b0}}, vec[2*N]};
    assign match  = ({dut_cout, dut_s} == golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            state      <= state_next;
            vec        <= vec_next;
            settle_cnt <= settle_cnt_next;
            err_count  <= err_next;
            first_fail <= first_fail_next;
            pass       <= pass_next;
        end
    end

    // An unknown comparison result falls into the else branch, so X/Z on the adder counts as a mismatch.
    always_comb begin
        miscompare = 1'b0;
        if (match) begin
            miscompare = 1'b0;
        end else begin
            miscompare = 1'b1;
        end
    end

`ifdef FA_BIST_STOP_ON_FAIL_EN
    assign stop_now = miscompare;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        vec_next        = vec;
        settle_cnt_next = settle_cnt;
        err_next        = err_count;
        first_fail_next = first_fail;
        pass_next       = pass;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    vec_next        = '0;
                    settle_cnt_next = '0;
                    err_next        = '0;
                    first_fail_next = '0;
                    pass_next       = 1'b0;
                    state_next      = SETTLE;
                end
            end
            SETTLE: begin
                settle_cnt_next = settle_cnt + 8'd1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (miscompare) begin
                    err_next = err_count + CW'(1);
                    if (err_count == '0) begin
                        first_fail_next = vec;
                    end
                end
                // The verdict uses the count including the vector checked at this edge.
                if (stop_now || (vec == V_LAST)) begin
                    pass_next  = (err_next == '0);
                    state_next = DONE;
                end else begin
                    vec_next        = vec + VW'(1);
                    settle_cnt_next = '0;
                    state_next      = SETTLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed self-checking bench for fa_bist_checker (N=1, SETTLE_CYCLES=2) with a fault-injectable adder model.
// Expectations follow FA_BIST_STOP_ON_FAIL_EN when that macro is defined.
module tb_fa_bist_checker;

    localparam int N      = 1;
    localparam int SETTLE = 2;

`ifdef FA_BIST_STOP_ON_FAIL_EN
    localparam int STUCK_EDGES = 6;
    localparam int STUCK_ERRS  = 1;
    localparam int INV_EDGES   = 3;
    localparam int INV_ERRS    = 1;
    localparam int STUCK_VEC   = 1;
    localparam int INV_VEC     = 0;
`else
    localparam int STUCK_EDGES = 24;
    localparam int STUCK_ERRS  = 4;
    localparam int INV_EDGES   = 24;
    localparam int INV_ERRS    = 8;
    localparam int STUCK_VEC   = 7;
    localparam int INV_VEC     = 7;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           busy;
    logic           done;
    logic           pass;
    logic [N-1:0]   dut_a;
    logic [N-1:0]   dut_b;
    logic           dut_cin;
    logic [N-1:0]   dut_s;
    logic           dut_cout;
    logic [2*N+1:0] err_count;
    logic [2*N:0]   first_fail;

    int             fault;
    logic [1:0]     good;
    int             compared;
    int             mismatched;
    int             edges;
    int             busy_cnt;
    int             waited;

    fa_bist_checker #(.N(N), .SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .dut_a      (dut_a),
        .dut_b      (dut_b),
        .dut_cin    (dut_cin),
        .dut_s      (dut_s),
        .dut_cout   (dut_cout),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    // Reference adder with selectable fault: 0 correct, 1 sum stuck-at-0, 2 carry-out inverted.
    assign good     = {1'b0, dut_a} + {1'b0, dut_b} + {1'b0, dut_cin};
    assign dut_s    = (fault == 1) ? 1'b0 : good[0];
    assign dut_cout = (fault == 2) ? ~good[1] : good[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_vec"}, 32'({dut_cin, dut_b, dut_a}), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_count), 32'd0);
        checkOutput({tag, "_first"}, 32'(first_fail), 32'd0);
    endtask

    // Starts a sweep and counts edges from the start edge until done is seen.
    task automatic applyStimulus(input bit hold, input bit check_vec, output int n_edges, output int n_busy);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        n_busy  = busy ? 1 : 0;
        n_edges = 0;
        if (check_vec) checkOutput("vec_first", 32'({dut_cin, dut_b, dut_a}), 32'd0);
        while (!done && n_edges < 200) begin
            @(posedge clk);
            n_edges++;
            @(negedge clk);
            if (busy) n_busy++;
            if (check_vec && !done && (n_edges % (SETTLE + 1)) == 0)
                checkOutput("vec_step", 32'({dut_cin, dut_b, dut_a}), 32'(n_edges / (SETTLE + 1)));
        end
        start = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        fault      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;

        #12;
        checkCleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct adder: full 24-cycle sweep with an in-order vector walk.
        fault = 0;
        applyStimulus(1'b0, 1'b1, edges, busy_cnt);
        checkOutput("ok_latency", 32'(edges), 32'd24);
        checkOutput("ok_busy_cycles", 32'(busy_cnt), 32'd24);
        checkOutput("ok_done", 32'(done), 32'd1);
        checkOutput("ok_busy_end", 32'(busy), 32'd0);
        checkOutput("ok_pass", 32'(pass), 32'd1);
        checkOutput("ok_err", 32'(err_count), 32'd0);
        checkOutput("ok_last_vec", 32'({dut_cin, dut_b, dut_a}), 32'd7);
        repeat (3) @(negedge clk);
        checkOutput("ok_hold_done", 32'(done), 32'd1);
        checkOutput("ok_hold_pass", 32'(pass), 32'd1);

        // Sum stuck at zero fails vectors 1, 2, 4 and 7.
        fault = 1;
        applyStimulus(1'b0, 1'b0, edges, busy_cnt);
        checkOutput("stuck_latency", 32'(edges), 32'(STUCK_EDGES));
        checkOutput("stuck_err", 32'(err_count), 32'(STUCK_ERRS));
        checkOutput("stuck_first", 32'(first_fail), 32'd1);
        checkOutput("stuck_pass", 32'(pass), 32'd0);
        checkOutput("stuck_done", 32'(done), 32'd1);
        checkOutput("stuck_vec", 32'({dut_cin, dut_b, dut_a}), 32'(STUCK_VEC));

        // Inverted carry-out fails every vector.
        fault = 2;
        applyStimulus(1'b0, 1'b0, edges, busy_cnt);
        checkOutput("inv_latency", 32'(edges), 32'(INV_EDGES));
        checkOutput("inv_err", 32'(err_count), 32'(INV_ERRS));
        checkOutput("inv_first", 32'(first_fail), 32'd0);
        checkOutput("inv_pass", 32'(pass), 32'd0);
        checkOutput("inv_vec", 32'({dut_cin, dut_b, dut_a}), 32'(INV_VEC));

        // Reset while vector 3 is applied clears everything without a clock edge.
        fault = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while ({dut_cin, dut_b, dut_a} != 3'd3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst_reach_v3", 32'({dut_cin, dut_b, dut_a}), 32'd3);
        checkOutput("rst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, edges, busy_cnt);
        checkOutput("post_rst_latency", 32'(edges), 32'd24);
        checkOutput("post_rst_pass", 32'(pass), 32'd1);
        checkOutput("post_rst_err", 32'(err_count), 32'd0);

        // start held through a failing sweep must not restart it.
        fault = 1;
        applyStimulus(1'b1, 1'b0, edges, busy_cnt);
        checkOutput("hold_latency", 32'(edges), 32'(STUCK_EDGES));
        checkOutput("hold_err", 32'(err_count), 32'(STUCK_ERRS));
        checkOutput("hold_pass", 32'(pass), 32'd0);

        // Restart from DONE with a good adder clears the earlier failures.
        fault = 0;
        applyStimulus(1'b0, 1'b0, edges, busy_cnt);
        checkOutput("rerun_latency", 32'(edges), 32'd24);
        checkOutput("rerun_err", 32'(err_count), 32'd0);
        checkOutput("rerun_first", 32'(first_fail), 32'd0);
        checkOutput("rerun_pass", 32'(pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
